// File: rtl/serial_add_sub_pkg.sv
// add_sub_pkg: shared mode encodings, FSM state type and default width
// for the bit-serial adder-subtractor.
`default_nettype none

package add_sub_pkg;

   localparam logic MODE_ADD      = 1'b0;
   localparam logic MODE_SUB      = 1'b1;
   localparam int   ADD_SUB_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_sub_fa_bit_cell.sv
// fa_bit_cell: combinational one-bit full adder used as the serial
// datapath's only arithmetic element.
`default_nettype none

module fa_bit_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

`default_nettype wire

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder-subtractor, LSB first, with
// start/done handshake. Optional zero flag: SERIAL_ADD_SUB_ZERO_FLAG_EN.
`default_nettype none

module serial_add_sub
   import add_sub_pkg::*;
#(
   parameter int WIDTH = ADD_SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int CW = $clog2(WIDTH);

   state_t           r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-2:0] r_sr;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

   fa_bit_cell u_fa (
      .x    (r_opa[0]),
      .y    (r_opb[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   // Sum bits enter at the MSB, so after WIDTH shifts bit 0 is at the bottom.
   assign w_res_next = {w_s, r_sr};
   assign w_last     = (r_count == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_sr     <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_opa   <= a;
                  r_opb   <= b ^ {WIDTH{mode}};
                  r_carry <= mode;
                  r_count <= '0;
                  r_state <= SHIFT;
               end else begin
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               r_sr    <= w_res_next[WIDTH-1:1];
               r_opa   <= r_opa >> 1;
               r_opb   <= r_opb >> 1;
               r_carry <= w_c;
               r_count <= r_count + CW'(1);
               if (w_last) begin
                  // r_carry here is the carry into the MSB.
                  r_result <= w_res_next;
                  r_cout   <= w_c;
                  r_ovf    <= w_c ^ r_carry;
                  r_state  <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
   logic r_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_zero <= 1'b0;
      end else if (r_state == SHIFT && w_last) begin
         r_zero <= (w_res_next == '0);
      end
   end

   assign zero = r_zero;
`endif

   assign busy      = (r_state == SHIFT);
   assign done      = (r_state == DONE);
   assign result    = r_result;
   assign carry_out = r_cout;
   assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub against
// an arithmetic reference model.
`default_nettype none

module tb_serial_add_sub;

   localparam int W    = 4;
   localparam int MODW = 1 << W;
   localparam int HALF = 1 << (W - 1);

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
   logic         zero;
`endif

   int errors = 0;
   int checks = 0;
   logic [W-1:0] prev_res;

   serial_add_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   task automatic model(input logic m, input int ua, input int ub,
                        output int r, output int c, output int v);
      int sum, sa, sb, t;
      sum = m ? (ua + MODW - ub) : (ua + ub);
      r   = sum % MODW;
      c   = sum / MODW;
      sa  = (ua >= HALF) ? ua - MODW : ua;
      sb  = (ub >= HALF) ? ub - MODW : ub;
      t   = m ? (sa - sb) : (sa + sb);
      v   = (t < -HALF || t > HALF - 1) ? 1 : 0;
   endtask

   // Entered and left at a negedge; leaves with done observed high.
   task automatic run_op(input logic m, input logic [W-1:0] opa, input logic [W-1:0] opb,
                         input bit ign_pulse);
      int er, ec, ev, cycles;
      model(m, int'(opa), int'(opb), er, ec, ev);
      start = 1'b1; mode = m; a = opa; b = opb;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; mode = 1'($urandom); a = W'($urandom); b = W'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      cycles = 0;
      while (done !== 1'b1 && cycles < 20) begin
         check("result_hold", 32'(result), 32'(prev_res));
         if (ign_pulse && cycles == 1) begin
            start = 1'b1; mode = ~m; a = ~opa; b = ~opb;
         end
         @(posedge clk);
         cycles++;
         @(negedge clk);
         start = 1'b0;
      end
      if (done !== 1'b1) begin
         check("done_timeout", 32'd0, 32'd1);
         return;
      end
      check("latency", 32'(cycles), 32'(W));
      check("busy_in_done", 32'(busy), 32'd0);
      check("result", 32'(result), 32'(er));
      check("carry_out", 32'(carry_out), 32'(ec));
      check("overflow", 32'(overflow), 32'(ev));
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
      check("zero", 32'(zero), (er == 0) ? 32'd1 : 32'd0);
`endif
      prev_res = W'(er);
   endtask

   task automatic idle();
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_result_hold", 32'(result), 32'(prev_res));
   endtask

   initial begin
      bit saw_done;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
      prev_res = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(carry_out), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
      check("rst_zero", 32'(zero), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      run_op(1'b0, 4'd3, 4'd5, 1'b0); idle();
      run_op(1'b1, 4'd5, 4'd3, 1'b0); idle();
      run_op(1'b1, 4'd3, 4'd5, 1'b0); idle();
      run_op(1'b1, 4'd8, 4'd1, 1'b0); idle();
      run_op(1'b0, 4'd15, 4'd1, 1'b0); idle();
      run_op(1'b0, 4'd6, 4'd7, 1'b1); idle();
      // back-to-back: second start is driven during DONE
      run_op(1'b1, 4'd2, 4'd9, 1'b0);
      run_op(1'b0, 4'd9, 4'd9, 1'b0); idle();

      // abort in the third SHIFT cycle
      start = 1'b1; mode = 1'b0; a = 4'd7; b = 4'd6;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_cout", 32'(carry_out), 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      prev_res = '0;
      saw_done = 1'b0;
      repeat (8) begin
         @(posedge clk); @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);

      repeat (40) begin
         run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
